// File: rtl/acc_cpu_mc.sv
// Multi-cycle accumulator CPU: external sync-read imem, internal data RAM,
// valid/ready I/O ports, run/pause, halt state and debug taps.
module acc_cpu_mc #(
  parameter int DW    = 8,
  parameter int AW    = 12,
  parameter int DEPTH = 256,
  localparam int IW   = 4 + AW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          run_i,
  output logic [AW-1:0] imem_addr_o,
  input  logic [IW-1:0] imem_data_i,
  input  logic [DW-1:0] in_data_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  output logic [DW-1:0] out_data_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [AW-1:0] pc_o,
  output logic [IW-1:0] ir_o,
  output logic [DW-1:0] acc_o,
  output logic [1:0]    flags_o,
  output logic [2:0]    state_o,
  output logic          halted_o
);

  localparam int DA = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_LDI = 4'h1, OP_LD  = 4'h2, OP_ST  = 4'h3,
    OP_ADD  = 4'h4, OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7,
    OP_XOR  = 4'h8, OP_ADDI = 4'h9, OP_JMP = 4'hA, OP_JZ = 4'hB,
    OP_JC   = 4'hC, OP_IN  = 4'hD, OP_OUT = 4'hE, OP_HLT = 4'hF
  } op_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [DW-1:0] acc_q, acc_d;
  logic          c_q, c_d;
  logic          z_q, z_d;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;
  logic          we;

  op_t           op;
  logic [AW-1:0] operand;
  logic [DA-1:0] daddr;
  logic [DW-1:0] imm;
  logic [AW-1:0] pc_inc;
  logic [DW:0]   sum;
  logic [DW-1:0] res;

  assign op      = op_t'(ir_q[IW-1:AW]);
  assign operand = ir_q[AW-1:0];
  assign daddr   = operand[DA-1:0];
  assign pc_inc  = pc_q + AW'(1);

  if (AW >= DW) begin : g_imm_trunc
    assign imm = operand[DW-1:0];
  end else begin : g_imm_zext
    assign imm = {{(DW-AW){1'b0}}, operand};
  end

  // Architectural state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      z_q     <= z_d;
    end
  end

  // Data RAM: write in EXEC for ST, registered read feeds MEM
  always_ff @(posedge clk_i) begin
    if (we) mem[daddr] <= acc_q;
    rdata_q <= mem[daddr];
  end

  // Next-state and datapath sequencing
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    c_d     = c_q;
    z_d     = z_q;
    we      = 1'b0;
    sum     = '0;
    res     = '0;
    unique case (state_q)
      S_FETCH: begin
        if (run_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        ir_d    = imem_data_i;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        unique case (op)
          OP_NOP: ;
          OP_LDI: begin
            acc_d = imm;
            z_d   = (imm == '0);
          end
          OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            state_d = S_MEM;
            pc_d    = pc_q;
          end
          OP_ST: we = 1'b1;
          OP_ADDI: begin
            sum   = {1'b0, acc_q} + {1'b0, imm};
            acc_d = sum[DW-1:0];
            c_d   = sum[DW];
            z_d   = (sum[DW-1:0] == '0);
          end
          OP_JMP: pc_d = operand;
          OP_JZ:  if (z_q) pc_d = operand;
          OP_JC:  if (c_q) pc_d = operand;
          OP_IN: begin
            if (in_valid_i) begin
              acc_d = in_data_i;
              z_d   = (in_data_i == '0);
            end else begin
              state_d = S_EXEC;
              pc_d    = pc_q;
            end
          end
          OP_OUT: begin
            if (!out_ready_i) begin
              state_d = S_EXEC;
              pc_d    = pc_q;
            end
          end
          OP_HLT: begin
            state_d = S_HALT;
            pc_d    = pc_q;
          end
        endcase
      end
      S_MEM: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        unique case (op)
          OP_ADD: begin
            sum = {1'b0, acc_q} + {1'b0, rdata_q};
            res = sum[DW-1:0];
            c_d = sum[DW];
          end
          OP_SUB: begin
            res = acc_q - rdata_q;
            c_d = (acc_q < rdata_q);
          end
          OP_AND: begin
            res = acc_q & rdata_q;
            c_d = 1'b0;
          end
          OP_OR: begin
            res = acc_q | rdata_q;
            c_d = 1'b0;
          end
          OP_XOR: begin
            res = acc_q ^ rdata_q;
            c_d = 1'b0;
          end
          default: res = rdata_q;
        endcase
        acc_d = res;
        z_d   = (res == '0);
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
  end

  assign imem_addr_o = pc_q;
  assign in_ready_o  = (state_q == S_EXEC) && (op == OP_IN);
  assign out_valid_o = (state_q == S_EXEC) && (op == OP_OUT);
  assign out_data_o  = out_valid_o ? acc_q : '0;
  assign pc_o        = pc_q;
  assign ir_o        = ir_q;
  assign acc_o       = acc_q;
  assign flags_o     = {c_q, z_q};
  assign state_o     = state_q;
  assign halted_o    = (state_q == S_HALT);

endmodule
